// File: rtl/packet_rx_framer_pkg.sv
// Shared constants for the ingress packet framer: state encodings, header word offsets
// and the running-CRC rule (bytewise XOR of every word before the CRC word).
package packet_rx_framer_pkg;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StDest    = 3'd1;
   localparam logic [2:0] StSize    = 3'd2;
   localparam logic [2:0] StPayload = 3'd3;
   localparam logic [2:0] StCrc     = 3'd4;
   localparam logic [2:0] StDrop    = 3'd5;

   localparam int unsigned OffSrc         = 0;
   localparam int unsigned OffDst         = 1;
   localparam int unsigned OffSize        = 2;
   localparam int unsigned OffPayloadBase = 3;

   // Wide enough for any practical word width; callers cast in and out.
   localparam int unsigned CrcMaxW = 64;

   function automatic logic [CrcMaxW-1:0] crc_step(input logic [CrcMaxW-1:0] crc,
                                                   input logic [CrcMaxW-1:0] word);
      return crc ^ word;
   endfunction

endpackage

// File: rtl/packet_rx_framer_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             clr_ni,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/packet_rx_framer.sv
// Ingress framer: writes each packet word into the current FIFO slot and commits the slot
// with winc only when the header is legal and the trailing CRC matches.
module packet_rx_framer
   import packet_rx_framer_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned OFF_W       = 4,
   parameter int unsigned MAX_PAYLOAD = 12,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_sop,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              wfull,
   output logic              wr_word,
   output logic [OFF_W-1:0]  waddr_in,
   output logic [DATA_W-1:0] wdata,
   output logic              winc,
   output logic              pkt_drop,
   output logic [CNT_W-1:0]  pkt_ok_cnt,
   output logic [CNT_W-1:0]  pkt_drop_cnt
);

   if (MAX_PAYLOAD + 4 > (1 << OFF_W)) begin : g_size_check
      $error("MAX_PAYLOAD+4 exceeds slot depth 2**OFF_W");
   end

   logic [2:0]        state_q, state_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] crc_q, crc_d;
   logic              wr_q, wr_d;
   logic [OFF_W-1:0]  waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              winc_q, winc_d;
   logic              drop_q, drop_d;

   logic              accept;
   logic              in_packet;
   logic              size_legal;
   logic [DATA_W-1:0] crc_next;

   // wfull only matters at a packet boundary; mid-packet no other writer can fill a slot.
   assign in_ready   = ((state_q == StIdle) || (state_q == StDrop)) ? !wfull : 1'b1;
   assign accept     = in_valid & in_ready;
   assign in_packet  = (state_q == StDest) || (state_q == StSize) ||
                       (state_q == StPayload) || (state_q == StCrc);
   assign size_legal = (in_data != '0) && (in_data <= DATA_W'(MAX_PAYLOAD));
   assign crc_next   = DATA_W'(crc_step(CrcMaxW'(crc_q), CrcMaxW'(in_data)));

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      rem_d   = rem_q;
      crc_d   = crc_q;
      wr_d    = 1'b0;
      waddr_d = off_q;
      wdata_d = in_data;
      winc_d  = 1'b0;
      drop_d  = 1'b0;
      if (accept) begin
         if (in_sop) begin
            // A new start-of-packet aborts whatever packet was in flight.
            drop_d  = in_packet;
            wr_d    = 1'b1;
            waddr_d = OFF_W'(OffSrc);
            off_d   = OFF_W'(OffDst);
            crc_d   = in_data;
            state_d = StDest;
         end else begin
            case (state_q)
               StDest: begin
                  wr_d    = 1'b1;
                  off_d   = off_q + OFF_W'(1);
                  crc_d   = crc_next;
                  state_d = StSize;
               end
               StSize: begin
                  wr_d  = 1'b1;
                  off_d = off_q + OFF_W'(1);
                  crc_d = crc_next;
                  rem_d = in_data;
                  if (size_legal) begin
                     state_d = StPayload;
                  end else begin
                     drop_d  = 1'b1;
                     state_d = StDrop;
                  end
               end
               StPayload: begin
                  wr_d  = 1'b1;
                  off_d = off_q + OFF_W'(1);
                  crc_d = crc_next;
                  rem_d = rem_q - DATA_W'(1);
                  if (rem_q == DATA_W'(1)) begin
                     state_d = StCrc;
                  end
               end
               StCrc: begin
                  // CRC word lands in the slot either way; only a match commits it.
                  wr_d    = 1'b1;
                  winc_d  = (in_data == crc_q);
                  drop_d  = (in_data != crc_q);
                  state_d = StIdle;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         off_q   <= '0;
         rem_q   <= '0;
         crc_q   <= '0;
         wr_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         winc_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         rem_q   <= rem_d;
         crc_q   <= crc_d;
         wr_q    <= wr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         winc_q  <= winc_d;
         drop_q  <= drop_d;
      end
   end

   assign wr_word  = wr_q;
   assign waddr_in = waddr_q;
   assign wdata    = wdata_q;
   assign winc     = winc_q;
   assign pkt_drop = drop_q;

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_ok_cnt (
      .clk_i (clk),
      .clr_ni(rst),
      .inc_i (winc_q),
      .cnt_o (pkt_ok_cnt)
   );

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_drop_cnt (
      .clk_i (clk),
      .clr_ni(rst),
      .inc_i (drop_q),
      .cnt_o (pkt_drop_cnt)
   );

endmodule

// File: tb/tb_packet_rx_framer.sv
// Directed self-checking bench for packet_rx_framer; a negedge monitor logs the write path.
module tb_packet_rx_framer;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_sop;
   logic [7:0] in_data;
   logic       in_ready;
   logic       wfull;
   logic       wr_word;
   logic [3:0] waddr_in;
   logic [7:0] wdata;
   logic       winc;
   logic       pkt_drop;
   logic [7:0] pkt_ok_cnt;
   logic [7:0] pkt_drop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   int addr_log[$];
   int data_log[$];
   int winc_n;
   int winc_addr;
   int winc_no_wr;
   int drop_n;
   int both_n;

   logic [7:0] good_pkt [8] = '{8'd100, 8'd10, 8'd4, 8'd0, 8'd1, 8'd2, 8'd3, 8'd106};

   packet_rx_framer #(
      .DATA_W     (8),
      .OFF_W      (4),
      .MAX_PAYLOAD(12),
      .CNT_W      (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_sop      (in_sop),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .wfull       (wfull),
      .wr_word     (wr_word),
      .waddr_in    (waddr_in),
      .wdata       (wdata),
      .winc        (winc),
      .pkt_drop    (pkt_drop),
      .pkt_ok_cnt  (pkt_ok_cnt),
      .pkt_drop_cnt(pkt_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_word) begin
         addr_log.push_back(int'(waddr_in));
         data_log.push_back(int'(wdata));
      end
      if (winc) begin
         winc_n++;
         winc_addr = int'(waddr_in);
         if (!wr_word) winc_no_wr++;
      end
      if (pkt_drop) drop_n++;
      if (winc && pkt_drop) both_n++;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      addr_log.delete();
      data_log.delete();
      winc_n     = 0;
      winc_addr  = -1;
      winc_no_wr = 0;
      drop_n     = 0;
      both_n     = 0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Presents one word from a negedge and returns at the negedge after it is accepted.
   task automatic send_word(input logic [7:0] d, input logic sop);
      logic rdy;
      in_valid = 1'b1;
      in_data  = d;
      in_sop   = sop;
      for (int t = 0; t < 50; t++) begin
         #1;
         rdy = in_ready;
         @(posedge clk);
         @(negedge clk);
         if (rdy) return;
      end
      check_eq("accept_timeout", 0, 1);
   endtask

   task automatic send_good(input int gap);
      for (int i = 0; i < 8; i++) begin
         send_word(good_pkt[i], i == 0);
         if (gap > 0) idle(1 + (i % gap));
      end
   endtask

   function automatic int log_addr(input int i);
      return (i < addr_log.size()) ? addr_log[i] : -1;
   endfunction

   function automatic int log_data(input int i);
      return (i < data_log.size()) ? data_log[i] : -1;
   endfunction

   task automatic check_good_slot(input string tag, input int base);
      for (int i = 0; i < 8; i++) begin
         check_eq({tag, "_addr"}, log_addr(base + i), i);
         check_eq({tag, "_data"}, log_data(base + i), int'(good_pkt[i]));
      end
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_data  = 8'd0;
      wfull    = 1'b0;
      clear_log();
      repeat (3) @(negedge clk);

      check_eq("rst_wr_word", int'(wr_word), 0);
      check_eq("rst_waddr", int'(waddr_in), 0);
      check_eq("rst_wdata", int'(wdata), 0);
      check_eq("rst_winc", int'(winc), 0);
      check_eq("rst_drop", int'(pkt_drop), 0);
      check_eq("rst_ok_cnt", int'(pkt_ok_cnt), 0);
      check_eq("rst_drop_cnt", int'(pkt_drop_cnt), 0);
      check_eq("rst_ready", int'(in_ready), 1);
      wfull = 1'b1;
      #1;
      check_eq("rst_ready_full", int'(in_ready), 0);
      wfull = 1'b0;
      rst = 1'b1;
      idle(2);

      // Good packet, continuous valid.
      clear_log();
      send_good(0);
      idle(3);
      check_eq("t1_wr_count", addr_log.size(), 8);
      check_good_slot("t1", 0);
      check_eq("t1_winc_n", winc_n, 1);
      check_eq("t1_winc_addr", winc_addr, 7);
      check_eq("t1_winc_with_wr", winc_no_wr, 0);
      check_eq("t1_drop_n", drop_n, 0);
      check_eq("t1_ok_cnt", int'(pkt_ok_cnt), 1);

      // Same packet with a bad CRC.
      clear_log();
      for (int i = 0; i < 7; i++) send_word(good_pkt[i], i == 0);
      send_word(8'd55, 1'b0);
      idle(3);
      check_eq("t2_wr_count", addr_log.size(), 8);
      check_eq("t2_last_addr", log_addr(7), 7);
      check_eq("t2_last_data", log_data(7), 55);
      check_eq("t2_winc_n", winc_n, 0);
      check_eq("t2_drop_n", drop_n, 1);
      check_eq("t2_drop_cnt", int'(pkt_drop_cnt), 1);
      check_eq("t2_ok_cnt", int'(pkt_ok_cnt), 1);

      // Size 0 header, stray words, then a good packet.
      clear_log();
      send_word(8'd255, 1'b1);
      send_word(8'd63, 1'b0);
      send_word(8'd0, 1'b0);
      check_eq("t3_drop_pulse", int'(pkt_drop), 1);
      send_word(8'd7, 1'b0);
      check_eq("t3_drop_one_cycle", int'(pkt_drop), 0);
      send_word(8'd8, 1'b0);
      send_word(8'd9, 1'b0);
      send_good(0);
      idle(3);
      check_eq("t3_wr_count", addr_log.size(), 11);
      check_eq("t3_size_addr", log_addr(2), 2);
      check_good_slot("t3", 3);
      check_eq("t3_drop_n", drop_n, 1);
      check_eq("t3_winc_n", winc_n, 1);
      check_eq("t3_drop_cnt", int'(pkt_drop_cnt), 2);
      check_eq("t3_ok_cnt", int'(pkt_ok_cnt), 2);

      // Back-pressure from wfull at packet start.
      clear_log();
      wfull    = 1'b1;
      in_valid = 1'b1;
      in_sop   = 1'b1;
      in_data  = good_pkt[0];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("t4_ready_low", int'(in_ready), 0);
      end
      check_eq("t4_no_write", addr_log.size(), 0);
      wfull = 1'b0;
      send_good(0);
      idle(3);
      check_eq("t4_wr_count", addr_log.size(), 8);
      check_eq("t4_first_addr", log_addr(0), 0);
      check_eq("t4_winc_n", winc_n, 1);
      check_eq("t4_ok_cnt", int'(pkt_ok_cnt), 3);

      // sop after two payload words aborts the packet in flight.
      clear_log();
      for (int i = 0; i < 5; i++) send_word(good_pkt[i], i == 0);
      send_word(good_pkt[0], 1'b1);
      check_eq("t5_abort_drop", int'(pkt_drop), 1);
      for (int i = 1; i < 8; i++) send_word(good_pkt[i], 1'b0);
      idle(3);
      check_eq("t5_wr_count", addr_log.size(), 13);
      check_good_slot("t5", 5);
      check_eq("t5_drop_n", drop_n, 1);
      check_eq("t5_winc_n", winc_n, 1);
      check_eq("t5_both", both_n, 0);
      check_eq("t5_drop_cnt", int'(pkt_drop_cnt), 3);
      check_eq("t5_ok_cnt", int'(pkt_ok_cnt), 4);

      // Gaps of 1..3 idle cycles between words.
      clear_log();
      send_good(3);
      idle(3);
      check_eq("t6_wr_count", addr_log.size(), 8);
      check_good_slot("t6", 0);
      check_eq("t6_winc_n", winc_n, 1);
      check_eq("t6_winc_addr", winc_addr, 7);
      check_eq("t6_ok_cnt", int'(pkt_ok_cnt), 5);

      // Reset in the middle of the payload abandons the packet silently.
      clear_log();
      for (int i = 0; i < 5; i++) send_word(good_pkt[i], i == 0);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      rst      = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      idle(2);
      check_eq("t7_winc_n", winc_n, 0);
      check_eq("t7_drop_n", drop_n, 0);
      check_eq("t7_ok_cnt", int'(pkt_ok_cnt), 0);
      check_eq("t7_drop_cnt", int'(pkt_drop_cnt), 0);
      clear_log();
      send_good(0);
      idle(3);
      check_good_slot("t7", 0);
      check_eq("t7_winc_after", winc_n, 1);
      check_eq("t7_ok_after", int'(pkt_ok_cnt), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
